// File: rtl/mod_key_expansion_if.sv
// mod_key_expansion_if: start/key/round-key bus for the AES-256 key expander; KEYEXP_STALL_EN adds stall_keyExp
interface mod_key_expansion_if;
  logic         start_keyExp;
  logic [255:0] inp_keyExp;
  logic [127:0] outp_keyExp;
  logic         wrEn_keyExp;
  logic [3:0]   idx_keyExp;
  logic         busy_keyExp;
  logic         done_keyExp;
`ifdef KEYEXP_STALL_EN
  logic         stall_keyExp;
  modport master(output start_keyExp, inp_keyExp, stall_keyExp,
                 input outp_keyExp, wrEn_keyExp, idx_keyExp, busy_keyExp, done_keyExp);
  modport slave(input start_keyExp, inp_keyExp, stall_keyExp,
                output outp_keyExp, wrEn_keyExp, idx_keyExp, busy_keyExp, done_keyExp);
`else
  modport master(output start_keyExp, inp_keyExp,
                 input outp_keyExp, wrEn_keyExp, idx_keyExp, busy_keyExp, done_keyExp);
  modport slave(input start_keyExp, inp_keyExp,
                output outp_keyExp, wrEn_keyExp, idx_keyExp, busy_keyExp, done_keyExp);
`endif
endinterface

// File: rtl/mod_key_expansion.sv
// mod_key_expansion: AES-256 key schedule, one 128-bit round key per cycle (15 keys per start).
// Optional macro KEYEXP_STALL_EN adds stall_keyExp, which freezes generation while high.
module mod_key_expansion #(
  parameter int N_RK = 15
) (
  input logic clk,
  input logic reset,
  mod_key_expansion_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [127:0] k2_q, k2_d, k1_q, k1_d, out_q, out_d, nk;
  logic wr_q, wr_d, busy_q, busy_d, done_q, done_d, stall;
  logic [31:0] lw, rot, st, t, w0, w1, w2, w3;
  logic [7:0] rc;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // GF(2^8) inverse as x^254 = x^2*x^4*...*x^128, followed by the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

`ifdef KEYEXP_STALL_EN
  assign stall = bus.stall_keyExp;
`else
  assign stall = 1'b0;
`endif

  // Even keys rotate and add Rcon; odd keys only substitute
  assign lw  = k1_q[31:0];
  assign rot = cnt_q[0] ? lw : {lw[23:0], lw[31:24]};
  assign rc  = 8'h01 << (cnt_q[3:1] - 3'd1);
  assign st  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign t   = st ^ {cnt_q[0] ? 8'h00 : rc, 24'h0};
  assign w0  = k2_q[127:96] ^ t;
  assign w1  = k2_q[95:64] ^ w0;
  assign w2  = k2_q[63:32] ^ w1;
  assign w3  = k2_q[31:0] ^ w2;
  assign nk  = {w0, w1, w2, w3};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    k2_d    = k2_q;
    k1_d    = k1_q;
    out_d   = out_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = bus.start_keyExp;
        if (bus.start_keyExp) begin
          state_d = GEN;
          cnt_d   = '0;
          k2_d    = bus.inp_keyExp[255:128];
          k1_d    = bus.inp_keyExp[127:0];
        end
      end
      GEN: if (!stall) begin
        wr_d  = 1'b1;
        idx_d = cnt_q;
        cnt_d = cnt_q + 4'd1;
        out_d = cnt_q == 4'd0 ? k2_q : cnt_q == 4'd1 ? k1_q : nk;
        k2_d  = cnt_q >= 4'd2 ? k1_q : k2_q;
        k1_d  = cnt_q >= 4'd2 ? nk : k1_q;
        state_d = cnt_q == 4'(N_RK - 1) ? DONE : GEN;
      end
      default: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      k2_q    <= '0;
      k1_q    <= '0;
      out_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      k2_q    <= k2_d;
      k1_q    <= k1_d;
      out_q   <= out_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.outp_keyExp = out_q;
  assign bus.wrEn_keyExp = wr_q;
  assign bus.idx_keyExp  = idx_q;
  assign bus.busy_keyExp = busy_q;
  assign bus.done_keyExp = done_q;
endmodule
